fifo_drain_ctrl: RTL

//   Downstream read stage for the 32-bit FIFObuffer. Drives the FIFO's RD/EN pins, absorbs its
//   1-cycle registered read latency and presents a valid/ready stream to the consumer. A 2-entry

---
 rtl/fifo_drain_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read stage behind FIFObuffer: issues RD/EN, absorbs the 1-cycle read latency, and presents a
// bubble-free valid/ready stream through a 2-entry buffer. Define FIFO_DRAIN_CNT_EN for word_count.
module fifo_drain_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             en,
   input  logic             flush,
   output logic             fifo_rd,
   output logic             fifo_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
`ifdef FIFO_DRAIN_CNT_EN
   output logic [CNT_W-1:0] word_count,
`endif
   output logic [1:0]       dbg_state
);

   // Handshake: a word transfers on any rising edge where out_valid & out_ready; while
   // out_valid & ~out_ready, out_valid and out_data hold unchanged.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       occ;
   logic             pend;
   logic [WIDTH-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
   logic             pop;
   logic [2:0]       fill;
   logic [1:0]       base;

   assign out_valid = (occ != 2'd0);
   assign out_data  = buf0;
   assign pop       = out_valid & out_ready;

   // fill is the occupancy after this edge; reads are only issued while it leaves a slot free
   assign fill      = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
   assign base      = occ - {1'b0, pop};
   assign fifo_en   = ~Rst;
   assign fifo_rd   = en & ~flush & ~fifo_empty & ~Rst & (fill < 3'd2);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_comb begin
      buf0_nxt = buf0;
      buf1_nxt = buf1;
      if (pop) buf0_nxt = buf1;
      if (pend) begin
         if (base == 2'd0) buf0_nxt = fifo_data;
         else              buf1_nxt = fifo_data;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en && !fifo_empty) state_nxt = RUN;
         end
         RUN: begin
            if (!en) begin
               if (occ != 2'd0 || pend) state_nxt = DRAIN;
               else                     state_nxt = IDLE;
            end else if (fifo_empty && occ == 2'd0 && !pend && !fifo_rd) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (en)                state_nxt = RUN;
            else if (fill == 3'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         occ   <= 2'd0;
         pend  <= 1'b0;
         buf0  <= '0;
         buf1  <= '0;
      end else begin
         state <= state_nxt;
         buf0  <= buf0_nxt;
         buf1  <= buf1_nxt;
         if (flush) begin
            occ  <= 2'd0;
            pend <= 1'b0;
         end else begin
            occ  <= fill[1:0];
            pend <= fifo_rd;
         end
      end
   end

`ifdef FIFO_DRAIN_CNT_EN
   // A pop in the flush cycle still reaches the consumer, so it is counted
   always_ff @(posedge Clk) begin
      if (Rst)      word_count <= '0;
      else if (pop) word_count <= word_count + 1'b1;
   end
`endif

endmodule
